// File: rtl/wbck_arbiter.sv
// Write-back arbiter: grants one of LSU/MDU/ALU per cycle onto the registered
// register-file write port. Define WBCK_STARVE_EN to build the starvation guard.
module wbck_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_LIM = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  // Channel order doubles as base priority: bit 0 (LSU) is highest.
  localparam int NCH = 3;

  logic [NCH-1:0]  valid_s;
  logic [NCH-1:0]  urgent_s;
  logic [NCH-1:0]  cand_s;
  logic [NCH-1:0]  grant_s;
  logic            xfer_s;
  logic [4:0]      win_rd_s;
  logic [XLEN-1:0] win_data_s;

  logic            rf_wen_d;
  logic            rf_wen_q;
  logic [4:0]      rf_waddr_d;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_d;
  logic [XLEN-1:0] rf_wdata_q;

  // One-hot of the lowest-index set bit, i.e. the highest base priority.
  function automatic logic [2:0] pick_first(input logic [2:0] req);
    logic [2:0] res;
    res = 3'b000;
    if (req[0]) begin
      res = 3'b001;
    end else if (req[1]) begin
      res = 3'b010;
    end else if (req[2]) begin
      res = 3'b100;
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  assign valid_s = {alu_valid, mdu_valid, lsu_valid};

`ifdef WBCK_STARVE_EN
  localparam logic [2:0] LIM = 3'(STARVE_LIM);

  logic [2:0] wait_q [NCH];
  logic [2:0] wait_d [NCH];

  // Wait counters: count denied cycles, saturate, clear on grant or idle.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      urgent_s[i] = (wait_q[i] == LIM);
      if (!valid_s[i] || grant_s[i]) begin
        wait_d[i] = 3'd0;
      end else if (wait_q[i] < LIM) begin
        wait_d[i] = wait_q[i] + 3'd1;
      end else begin
        wait_d[i] = wait_q[i];
      end
    end
  end

  // Wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        wait_q[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end
`else
  assign urgent_s = 3'b000;
`endif

  // Arbitration: urgent requesters first, then base priority; nothing in reset.
  always_comb begin
    cand_s  = valid_s;
    grant_s = 3'b000;
    if ((valid_s & urgent_s) != 3'b000) begin
      cand_s = valid_s & urgent_s;
    end else begin
      cand_s = valid_s;
    end
    if (rst_n) begin
      grant_s = pick_first(cand_s);
    end else begin
      grant_s = 3'b000;
    end
  end

  assign lsu_ready = grant_s[0];
  assign mdu_ready = grant_s[1];
  assign alu_ready = grant_s[2];

  // Winner payload mux.
  always_comb begin
    xfer_s     = 1'b0;
    win_rd_s   = 5'd0;
    win_data_s = {XLEN{1'b0}};
    case (grant_s)
      3'b001: begin
        xfer_s     = 1'b1;
        win_rd_s   = lsu_rd;
        win_data_s = lsu_data;
      end
      3'b010: begin
        xfer_s     = 1'b1;
        win_rd_s   = mdu_rd;
        win_data_s = mdu_data;
      end
      3'b100: begin
        xfer_s     = 1'b1;
        win_rd_s   = alu_rd;
        win_data_s = alu_data;
      end
      default: begin
        xfer_s     = 1'b0;
        win_rd_s   = 5'd0;
        win_data_s = {XLEN{1'b0}};
      end
    endcase
  end

  // Write-port next state: x0 writes are consumed but leave address/data held.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (xfer_s && (win_rd_s != 5'd0)) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = win_rd_s;
      rf_wdata_d = win_data_s;
    end else begin
      rf_wen_d   = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
    end
  end

  // Write-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= {XLEN{1'b0}};
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule
